// File: rtl/ca_engine.sv
// ca_engine: one-dimensional elementary cellular-automaton engine with a run controller.
//
// Holds a WIDTH-cell register and applies an 8-bit Wolfram rule for a requested number of
// generations. Boundary handling is fixed (external left/right bits), periodic wrap or mirror.
// A run can be paused with hold, aborted by loading new cells, and ends with a one-cycle done.
//
// Ports:
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset
//   rule           Wolfram rule, latched at start
//   boundary_mode  0 fixed, 1 wrap, 2 mirror, 3 fixed; latched at start
//   left, right    fixed-mode edge neighbours, sampled live on every step
//   state          load value for the cells
//   set_state      load state this cycle (highest priority, aborts a run)
//   start          begin a run of gens generations (idle only)
//   gens           generation count, latched at start
//   hold           freeze stepping while running
//   out            cell register
//   busy           run in progress
//   done           one-cycle pulse at run completion
//   gen_count      generations completed in the current or last run
module ca_engine #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rule,
  input  logic [1:0]       boundary_mode,
  input  logic             left,
  input  logic             right,
  input  logic [WIDTH-1:0] state,
  input  logic             set_state,
  input  logic             start,
  input  logic [GEN_W-1:0] gens,
  input  logic             hold,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic [GEN_W-1:0] gen_count
);

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } ctrl_state_e;

  localparam logic [1:0] ModeWrap   = 2'd1;
  localparam logic [1:0] ModeMirror = 2'd2;

  ctrl_state_e      ctrl_q;
  logic [7:0]       rule_q;
  logic [1:0]       mode_q;
  logic [GEN_W-1:0] rem_q;

  logic             l_edge;
  logic             r_edge;
  logic [WIDTH+1:0] ext;
  logic [WIDTH-1:0] next_cells;

  // Neighbourhood of cell i is ext[i] (left), ext[i+1] (self), ext[i+2] (right); the two
  // extra bits carry the boundary neighbours so every cell uses the same lookup.
  always_comb begin
    l_edge = left;
    r_edge = right;
    case (mode_q)
      ModeWrap: begin
        l_edge = out[WIDTH-1];
        r_edge = out[0];
      end
      ModeMirror: begin
        l_edge = out[0];
        r_edge = out[WIDTH-1];
      end
      default: begin
        // Modes 0 and 3: fixed external neighbours.
      end
    endcase
    ext = {r_edge, out, l_edge};
    next_cells = '0;
    for (int i = 0; i < WIDTH; i++) begin
      next_cells[i] = rule_q[{ext[i], ext[i+1], ext[i+2]}];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= StIdle;
      rule_q    <= '0;
      mode_q    <= '0;
      rem_q     <= '0;
      out       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      gen_count <= '0;
    end else begin
      done <= 1'b0;
      if (set_state) begin
        // Load wins over everything; an active run is abandoned without done and
        // gen_count keeps the number of steps already taken.
        out    <= state;
        ctrl_q <= StIdle;
        busy   <= 1'b0;
      end else begin
        unique case (ctrl_q)
          StIdle: begin
            if (start) begin
              gen_count <= '0;
              if (gens != '0) begin
                rule_q <= rule;
                mode_q <= boundary_mode;
                rem_q  <= gens;
                ctrl_q <= StRun;
                busy   <= 1'b1;
              end else begin
                done <= 1'b1;
              end
            end
          end
          StRun: begin
            if (!hold) begin
              out       <= next_cells;
              rem_q     <= rem_q - GEN_W'(1);
              gen_count <= gen_count + GEN_W'(1);
              if (rem_q == GEN_W'(1)) begin
                ctrl_q <= StIdle;
                busy   <= 1'b0;
                done   <= 1'b1;
              end
            end
          end
          default: ctrl_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ca_engine.sv
module tb_ca_engine;

  localparam int unsigned W = 8;
  localparam int unsigned G = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   rule;
  logic [1:0]   boundary_mode;
  logic         left;
  logic         right;
  logic [W-1:0] state;
  logic         set_state;
  logic         start;
  logic [G-1:0] gens;
  logic         hold;
  logic [W-1:0] out;
  logic         busy;
  logic         done;
  logic [G-1:0] gen_count;

  ca_engine #(.WIDTH(W), .GEN_W(G)) dut (
    .clk          (clk),
    .rst          (rst),
    .rule         (rule),
    .boundary_mode(boundary_mode),
    .left         (left),
    .right        (right),
    .state        (state),
    .set_state    (set_state),
    .start        (start),
    .gens         (gens),
    .hold         (hold),
    .out          (out),
    .busy         (busy),
    .done         (done),
    .gen_count    (gen_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] cells;
    logic [G-1:0] count;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse consumes one expected completion.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pulse (out=0x%0h)", out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_out"}, 32'(out), 32'(e.cells));
        check({e.name, "_gen_count"}, 32'(gen_count), 32'(e.count));
        check({e.name, "_busy_at_done"}, 32'(busy), 32'd0);
      end
    end
  end

  task automatic load(input logic [W-1:0] v);
    @(negedge clk);
    state     = v;
    set_state = 1'b1;
    @(negedge clk);
    set_state = 1'b0;
  endtask

  // Issue a run, optionally holding for hold_len cycles starting at busy cycle hold_at,
  // and check the number of busy cycles. Rule/mode inputs are scrambled after start.
  task automatic run(input string name, input logic [7:0] r, input logic [1:0] m,
                     input logic [G-1:0] g, input int hold_at, input int hold_len,
                     input logic [W-1:0] exp_out);
    int cnt;
    bit ended;
    cnt   = 0;
    ended = 1'b0;
    exp_q.push_back('{name, exp_out, g});
    @(negedge clk);
    rule          = r;
    boundary_mode = m;
    gens          = g;
    start         = 1'b1;
    @(negedge clk);
    start         = 1'b0;
    rule          = ~r;
    boundary_mode = m ^ 2'b01;
    for (int guard = 0; guard < 200; guard++) begin
      if (!busy) begin
        ended = 1'b1;
        break;
      end
      cnt++;
      hold = (cnt >= hold_at) && (cnt < hold_at + hold_len);
      @(negedge clk);
    end
    hold = 1'b0;
    if (!ended) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: busy still 1 after 200 cycles, expected it to drop", name);
    end
    check({name, "_busy_cycles"}, 32'(cnt), 32'(int'(g) + hold_len));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    rule          = '0;
    boundary_mode = '0;
    left          = 1'b0;
    right         = 1'b0;
    state         = '0;
    set_state     = 1'b0;
    start         = 1'b0;
    gens          = '0;
    hold          = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out", 32'(out), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_gen_count", 32'(gen_count), 32'd0);
    rst = 1'b0;

    // Single steps of rule 90 from a lone cell under each boundary mode.
    load(8'h01);
    run("r90_wrap", 8'd90, 2'd1, 16'd1, 0, 0, 8'h82);
    load(8'h01);
    run("r90_fixed00", 8'd90, 2'd0, 16'd1, 0, 0, 8'h02);
    load(8'h01);
    run("r90_mirror", 8'd90, 2'd2, 16'd1, 0, 0, 8'h03);
    left  = 1'b1;
    right = 1'b1;
    load(8'h01);
    run("r90_fixed11", 8'd90, 2'd0, 16'd1, 0, 0, 8'h83);
    right = 1'b0;
    load(8'h01);
    run("r90_mode3_l1", 8'd90, 2'd3, 16'd1, 0, 0, 8'h03);
    left  = 1'b0;

    // Identity rule over five generations.
    load(8'hA5);
    run("r204_x5", 8'd204, 2'd1, 16'd5, 0, 0, 8'hA5);

    // Three generations with a two-cycle hold in the middle: 01 -> 82 -> 44 -> AA.
    load(8'h01);
    run("r90_hold", 8'd90, 2'd1, 16'd3, 2, 2, 8'hAA);

    // Abort by load after four steps; a start mid-run is ignored.
    load(8'h01);
    @(negedge clk);
    rule          = 8'd90;
    boundary_mode = 2'd1;
    gens          = 16'd10;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort_busy_after_start", 32'(busy), 32'd1);
    @(negedge clk);
    gens  = 16'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_out_gen4", 32'(out), 32'h00);
    check("abort_count_before", 32'(gen_count), 32'd4);
    state     = 8'h3C;
    set_state = 1'b1;
    @(negedge clk);
    set_state = 1'b0;
    check("abort_out", 32'(out), 32'h3C);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_gen_count", 32'(gen_count), 32'd4);
    repeat (3) @(negedge clk);
    check("abort_stays_idle", 32'(busy), 32'd0);

    // start together with set_state: load happens, start ignored.
    state     = 8'h5A;
    set_state = 1'b1;
    gens      = 16'd1;
    start     = 1'b1;
    @(negedge clk);
    set_state = 1'b0;
    start     = 1'b0;
    check("start_setstate_busy", 32'(busy), 32'd0);
    check("start_setstate_out", 32'(out), 32'h5A);
    check("start_setstate_count", 32'(gen_count), 32'd4);

    // Zero-generation request: immediate done, cells untouched, count cleared.
    run("gens0", 8'd90, 2'd1, 16'd0, 0, 0, 8'h5A);

    // Reset in the middle of a run.
    load(8'h01);
    @(negedge clk);
    rule          = 8'd90;
    boundary_mode = 2'd1;
    gens          = 16'd10;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out", 32'(out), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_gen_count", 32'(gen_count), 32'd0);
    rst = 1'b0;

    // Engine is usable again after the reset.
    load(8'h01);
    run("after_rst", 8'd90, 2'd1, 16'd1, 0, 0, 8'h82);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ca_engine.md
# ca_engine

Parametrised one-dimensional elementary cellular-automaton engine with a run controller. It holds a `WIDTH`-cell register, applies an 8-bit Wolfram rule for a requested number of generations, and supports selectable boundary handling (fixed, periodic, mirror), pause, abort-by-load and a `done` pulse. It is the multi-generation successor to the free-running 32-cell array and sits between the host register interface and the display/readout logic.

## Interface
- `WIDTH`, 32: number of cells, ≥ 3.
- `GEN_W`, 16: width of the generation request and generation counter.

- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rule`  in  8  Wolfram rule; latched at `start`.
- `boundary_mode`  in  2  0 = fixed, 1 = periodic wrap, 2 = mirror, 3 = treated as fixed; latched at `start`.
- `left`  in  1  constant left neighbour of cell 0 in fixed mode; sampled live every step.
- `right`  in  1  constant right neighbour of cell `WIDTH-1` in fixed mode; sampled live every step.
- `state`  in  `WIDTH`  load value for the cell register.
- `set_state`  in  1  load `state` into the cells this cycle.
- `start`  in  1  begin a run of `gens` generations; accepted only when idle.
- `gens`  in  `GEN_W`  generations to compute; latched at `start`.
- `hold`  in  1  freeze stepping while running.
- `out`  out  `WIDTH`  current cell register.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at run completion.
- `gen_count`  out  `GEN_W`  generations completed in the current or last run.

## Operation
- Cell i: left neighbour `out[i-1]`, right neighbour `out[i+1]`. Next value = `rule_q[{l, self, r}]`, with `l` as the MSB of the index.
- Boundaries:
  - Fixed: cell 0 left = `left`; cell `WIDTH-1` right = `right`.
  - Wrap: cell 0 left = `out[WIDTH-1]`; cell `WIDTH-1` right = `out[0]`.
  - Mirror: each edge cell uses itself as its missing neighbour.
- All cells update simultaneously, one generation per step.
- FSM:
  - IDLE: `busy`=0. On `start` with `gens`≠0, latch `rule`, `boundary_mode` and `gens` into `rem`; clear `gen_count`; go to RUN. On `start` with `gens`=0, clear `gen_count`, pulse `done`, stay in IDLE, cells unchanged.
  - RUN: `busy`=1. Each cycle with `hold`=0: step the cells, `rem`−1, `gen_count`+1. When `rem`=1 at a step, that step is the last: return to IDLE and pulse `done`. With `hold`=1: nothing changes.
- `set_state` has top priority over stepping in any state. In RUN it loads `state`, aborts to IDLE with no `done` pulse, and leaves `gen_count` at its current value.
- `start` while `busy`, or in the same cycle as `set_state`, is ignored.
- `gen_count` wraps modulo 2^`GEN_W`. It cannot exceed `gens`, so no overflow occurs within a run.

## Timing
- Reset values: `out`=0, `busy`=0, `done`=0, `gen_count`=0, `rule_q`=0, `mode_q`=0, FSM in IDLE. `rst` overrides `set_state` and `start`, including mid-run.
- `start` sampled at edge E0: `busy`=1 after E0. Generation k appears on `out` after edge E0+k (no holds).
- After edge E0+`gens`: `busy`=0, `done`=1 for exactly one cycle, `gen_count`=`gens`.
- Each `hold` cycle delays completion by one cycle.
- `set_state` loads at the next edge; the new `out` is visible one cycle later. All outputs are registered.
- Changes to `rule`/`boundary_mode` during a run have no effect. Changes to `left`/`right` take effect at the next step.

## Test plan
- `WIDTH`=8, `rule`=90, wrap, load 0x01, `gens`=1 -> after 1 step `out`=0x82, `done` pulse, `gen_count`=1.
- Same seed and rule, fixed mode, `left`=`right`=0 -> 0x02. Mirror mode -> 0x03.
- `rule`=204, any mode, load 0xA5, `gens`=5 -> `out` stays 0xA5; `busy` high exactly 5 cycles; `gen_count`=5.
- `gens`=3 with `hold` high for 2 cycles mid-run -> `busy` high 5 cycles; `done` 1 cycle; `gen_count`=3.
- `gens`=10, `set_state`=0x3C after 4 steps -> `out`=0x3C, `busy` drops, no `done`, `gen_count`=4. `start` during the run is ignored.
- `start` with `gens`=0 -> `done` pulse the next cycle, `busy` stays 0, `out` unchanged. `rst` mid-run -> all outputs at reset values the next cycle.
